// File: rtl/cxu_l2_initiator_if.sv
// CXU-L2 initiator bundle: core command/response side and L2 request/response side.
// master = initiator view, slave = core + L2 environment view.
interface cxu_l2_initiator_if #(
    parameter int CXU_N_CXUS    = 1,
    parameter int CXU_FUNC_ID_W = 10,
    parameter int CXU_DATA_W    = 32,
    parameter int CXU_STATUS_W  = 3
);
    localparam int CXU_ID_W = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [CXU_ID_W-1:0]      cmd_cxu;
    logic [CXU_FUNC_ID_W-1:0] cmd_func;
    logic [CXU_DATA_W-1:0]    cmd_data0;
    logic [CXU_DATA_W-1:0]    cmd_data1;

    logic                     req_valid;
    logic                     req_ready;
    logic [CXU_ID_W-1:0]      req_cxu;
    logic [CXU_FUNC_ID_W-1:0] req_func;
    logic [CXU_DATA_W-1:0]    req_data0;
    logic [CXU_DATA_W-1:0]    req_data1;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [CXU_STATUS_W-1:0]  resp_status;
    logic [CXU_DATA_W-1:0]    resp_data;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [CXU_STATUS_W-1:0]  rsp_status;
    logic [CXU_DATA_W-1:0]    rsp_data;

    modport master (
        input  cmd_valid, cmd_cxu, cmd_func, cmd_data0, cmd_data1,
        output cmd_ready,
        output req_valid, req_cxu, req_func, req_data0, req_data1,
        input  req_ready,
        input  resp_valid, resp_status, resp_data,
        output resp_ready,
        output rsp_valid, rsp_status, rsp_data,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_cxu, cmd_func, cmd_data0, cmd_data1,
        input  cmd_ready,
        input  req_valid, req_cxu, req_func, req_data0, req_data1,
        output req_ready,
        output resp_valid, resp_status, resp_data,
        input  resp_ready,
        input  rsp_valid, rsp_status, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/cxu_l2_initiator.sv
// CXU-L2 initiator: issues core commands as L2 requests and returns responses
// in order through a credit-protected FIFO.
// Ports: clk, rst_n (async, active low), clk_en (global hold), bus (master
// view: cmd/req/resp/rsp handshakes), busy (credits outstanding),
// err_unexp (sticky: response with nothing in flight).
// Optional macro CXU_L2_INITIATOR_TIMEOUT_EN adds a response watchdog and
// the sticky err_timeout output.
module cxu_l2_initiator #(
    parameter int CXU_N_CXUS    = 1,
    parameter int CXU_FUNC_ID_W = 10,
    parameter int CXU_DATA_W    = 32,
    parameter int CXU_STATUS_W  = 3,
    parameter int DEPTH         = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    cxu_l2_initiator_if.master    bus,
    output logic                  busy,
    output logic                  err_unexp
`ifdef CXU_L2_INITIATOR_TIMEOUT_EN
    ,
    output logic                  err_timeout
`endif
);
    localparam int CXU_ID_W = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int ENT_W    = CXU_STATUS_W + CXU_DATA_W;

    logic                     req_valid_q, req_valid_d;
    logic [CXU_ID_W-1:0]      req_cxu_q;
    logic [CXU_FUNC_ID_W-1:0] req_func_q;
    logic [CXU_DATA_W-1:0]    req_data0_q;
    logic [CXU_DATA_W-1:0]    req_data1_q;

    logic [CNT_W-1:0]         credit_q, credit_d;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [IDX_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]         mem_q [DEPTH];
    logic                     err_unexp_q, err_unexp_d;

    logic                     cmd_ready;
    logic                     cmd_hs, req_hs, rsp_hs;
    logic                     resp_acc, resp_push, push;
    logic                     to_fire;
    logic [ENT_W-1:0]         push_ent;

    assign cmd_ready = clk_en && (credit_q < CNT_W'(DEPTH))
                       && (!req_valid_q || bus.req_ready);
    assign cmd_hs    = cmd_ready && bus.cmd_valid;
    assign req_hs    = clk_en && req_valid_q && bus.req_ready;
    assign rsp_hs    = clk_en && (count_q != '0) && bus.rsp_ready;
    assign resp_acc  = clk_en && bus.resp_valid;
    // A response with nothing outstanding is dropped, never stored.
    assign resp_push = resp_acc && (inflight_q != '0);

    assign bus.cmd_ready  = cmd_ready;
    assign bus.req_valid  = req_valid_q;
    assign bus.req_cxu    = req_cxu_q;
    assign bus.req_func   = req_func_q;
    assign bus.req_data0  = req_data0_q;
    assign bus.req_data1  = req_data1_q;
    assign bus.resp_ready = clk_en;
    assign bus.rsp_valid  = (count_q != '0);
    assign {bus.rsp_status, bus.rsp_data} = mem_q[rd_ptr_q];
    assign busy      = (credit_q != '0);
    assign err_unexp = err_unexp_q;

`ifdef CXU_L2_INITIATOR_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_to_q, err_to_d;

    // Fires on the cycle the count would reach TIMEOUT; a real response
    // in the same cycle wins and restarts the watchdog.
    assign to_fire = clk_en && (inflight_q != '0) && !resp_push
                     && (tmr_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmr_d    = tmr_q;
        err_to_d = err_to_q | to_fire;
        if (clk_en) begin
            if (resp_acc || inflight_q == '0 || to_fire) begin
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q    <= '0;
            err_to_q <= 1'b0;
        end else begin
            tmr_q    <= tmr_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign to_fire = 1'b0;
`endif

    assign push     = resp_push || to_fire;
    assign push_ent = resp_push ? {bus.resp_status, bus.resp_data}
                                : {{CXU_STATUS_W{1'b1}}, {CXU_DATA_W{1'b0}}};

    always_comb begin
        req_valid_d = req_valid_q;
        if (cmd_hs) begin
            req_valid_d = 1'b1;
        end else if (req_hs) begin
            req_valid_d = 1'b0;
        end
        credit_d    = credit_q + CNT_W'(cmd_hs) - CNT_W'(rsp_hs);
        inflight_d  = inflight_q + CNT_W'(req_hs) - CNT_W'(push);
        count_d     = count_q + CNT_W'(push) - CNT_W'(rsp_hs);
        wr_ptr_d    = push ? wr_ptr_q + IDX_W'(1) : wr_ptr_q;
        rd_ptr_d    = rsp_hs ? rd_ptr_q + IDX_W'(1) : rd_ptr_q;
        err_unexp_d = err_unexp_q | (resp_acc && inflight_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            credit_q    <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_unexp_q <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            credit_q    <= credit_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    // Payload storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            req_cxu_q   <= bus.cmd_cxu;
            req_func_q  <= bus.cmd_func;
            req_data0_q <= bus.cmd_data0;
            req_data1_q <= bus.cmd_data1;
        end
        if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end
endmodule

// File: tb/tb_cxu_l2_initiator.sv
// Scoreboard bench for cxu_l2_initiator: model CXU answers each request,
// expected responses are queued at command accept and compared at pop.
module tb_cxu_l2_initiator;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b1;
    logic busy;
    logic err_unexp;
`ifdef CXU_L2_INITIATOR_TIMEOUT_EN
    logic err_timeout;
`endif

    cxu_l2_initiator_if bus ();

    cxu_l2_initiator #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .bus       (bus),
        .busy      (busy),
        .err_unexp (err_unexp)
`ifdef CXU_L2_INITIATOR_TIMEOUT_EN
        ,
        .err_timeout (err_timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_cmd = 0;
    int n_req = 0;
    int inj_req = 0;
    int inj_done = 0;
    bit resp_en = 1'b1;
    bit to_mode = 1'b0;
    logic [34:0] exp_q[$];
    logic [34:0] pq[$];

    function automatic logic [34:0] model(input logic [9:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        return {f[2:0] ^ 3'd5, a + b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model L2 CXU: answers each request the cycle after its handshake.
    initial begin
        logic [34:0] e;
        bus.resp_valid  = 1'b0;
        bus.resp_status = '0;
        bus.resp_data   = '0;
        forever begin
            @(negedge clk);
            if (clk_en && bus.req_valid && bus.req_ready)
                pq.push_back(model(bus.req_func, bus.req_data0,
                                   bus.req_data1));
            @(posedge clk);
            #1;
            bus.resp_valid = 1'b0;
            if (inj_req != inj_done) begin
                inj_done++;
                bus.resp_valid = 1'b1;
                {bus.resp_status, bus.resp_data} = {3'd3, 32'hDEAD};
            end else if (resp_en && pq.size() != 0) begin
                e = pq.pop_front();
                bus.resp_valid = 1'b1;
                {bus.resp_status, bus.resp_data} = e;
            end
        end
    end

    task automatic tick();
        logic [34:0] e;
        @(negedge clk);
        if (clk_en && bus.cmd_valid && bus.cmd_ready) begin
            n_cmd++;
            exp_q.push_back(to_mode ? {3'b111, 32'd0}
                            : model(bus.cmd_func, bus.cmd_data0,
                                    bus.cmd_data1));
        end
        if (clk_en && bus.req_valid && bus.req_ready) n_req++;
        if (clk_en && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_extra", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {bus.rsp_status, bus.rsp_data}, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        chk("drain_left", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic send(input logic [9:0] f, input logic [31:0] a,
                        input logic [31:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_func  = f;
        bus.cmd_data0 = a;
        bus.cmd_data1 = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int r0;
        bus.cmd_valid = 1'b0;
        bus.cmd_cxu   = '0;
        bus.cmd_func  = '0;
        bus.cmd_data0 = '0;
        bus.cmd_data1 = '0;
        bus.req_ready = 1'b1;
        bus.rsp_ready = 1'b0;

        #12;
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_unexp", err_unexp, 0);
`ifdef CXU_L2_INITIATOR_TIMEOUT_EN
        chk("rst_err_timeout", err_timeout, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single command through the whole path.
        bus.rsp_ready = 1'b1;
        send(10'd5, 32'd3, 32'd4);
        #1;
        chk("t1_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t1_req_valid", bus.req_valid, 1);
        chk("t1_req_func", bus.req_func, 5);
        chk("t1_req_data0", bus.req_data0, 3);
        tick();
        chk("t1_req_clear", bus.req_valid, 0);
        chk("t1_rsp_early", bus.rsp_valid, 0);
        tick();
        chk("t1_rsp_valid", bus.rsp_valid, 1);
        chk("t1_rsp_data", bus.rsp_data, 7);
        chk("t1_rsp_status", bus.rsp_status, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_busy_drop", busy, 0);
        bus.rsp_ready = 1'b0;

        // Clock enable low blocks both handshakes.
        clk_en = 1'b0;
        send(10'd1, 32'd0, 32'd0);
        #1;
        chk("ce_cmd_ready", bus.cmd_ready, 0);
        chk("ce_resp_ready", bus.resp_ready, 0);
        bus.cmd_valid = 1'b0;
        clk_en = 1'b1;

        // Credit backpressure.
        c0 = n_cmd;
        for (int i = 0; i < 6; i++) begin
            send(10'(i + 1), 32'(10 + i), 32'd0);
            #1;
            if (i >= 4) chk("bp_cmd_ready", bus.cmd_ready, 0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("bp_accepted", n_cmd - c0, 4);
        repeat (4) tick();
        send(10'd7, 32'd14, 32'd0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_full_ready", bus.cmd_ready, 0);
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_ready_back", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        drain();

        // Request stall with req_ready low.
        bus.req_ready = 1'b0;
        send(10'd9, 32'd21, 32'd22);
        #1;
        chk("st_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        r0 = n_req;
        for (int i = 0; i < 3; i++) begin
            chk("st_req_valid", bus.req_valid, 1);
            chk("st_req_func", bus.req_func, 9);
            chk("st_req_data0", bus.req_data0, 21);
            chk("st_req_data1", bus.req_data1, 22);
            chk("st_cmd_block", bus.cmd_ready, 0);
            tick();
        end
        bus.req_ready = 1'b1;
        tick();
        chk("st_one_hs", n_req - r0, 1);
        chk("st_req_clear", bus.req_valid, 0);
        drain();

        // Push and pop every cycle at constant credit, wrapping pointers.
        for (int i = 0; i < 4; i++) begin
            send(10'(20 + i), 32'(40 + i), 32'd1);
            tick();
        end
        bus.cmd_valid = 1'b0;
        repeat (5) tick();
        bus.rsp_ready = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            send(10'(i), 32'(200 + i), 32'(i));
            #1;
            chk("sim_cmd_ready", bus.cmd_ready, 1);
            chk("sim_rsp_valid", bus.rsp_valid, 1);
            tick();
        end
        bus.rsp_ready = 1'b0;
        send(10'd3, 32'd300, 32'd0);
        #1;
        chk("sim_last_slot", bus.cmd_ready, 1);
        tick();
        chk("sim_credit_full", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        drain();

        // Response with nothing in flight.
        inj_req++;
        repeat (3) tick();
        chk("ux_err", err_unexp, 1);
        chk("ux_rsp_valid", bus.rsp_valid, 0);
        chk("ux_busy", busy, 0);
        repeat (3) tick();
        chk("ux_err_held", err_unexp, 1);

        // Asynchronous reset with two requests outstanding.
        resp_en = 1'b0;
        r0 = n_req;
        send(10'd2, 32'd60, 32'd0);
        tick();
        send(10'd3, 32'd61, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 10 && n_req - r0 < 2; k++) tick();
        chk("ar_issued", n_req - r0, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_req_valid", bus.req_valid, 0);
        chk("ar_rsp_valid", bus.rsp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_err_clear", err_unexp, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (4) tick();
        chk("ar_stale_err", err_unexp, 1);
        chk("ar_stale_rsp", bus.rsp_valid, 0);
        chk("ar_stale_busy", busy, 0);

`ifdef CXU_L2_INITIATOR_TIMEOUT_EN
        // Unanswered request resolved by the watchdog.
        resp_en = 1'b0;
        to_mode = 1'b1;
        send(10'd4, 32'd55, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        to_mode = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        chk("to_done", exp_q.size(), 0);
        chk("to_flag", err_timeout, 1);
        bus.rsp_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cxu_l2_initiator.md
Name: cxu_l2_initiator

Overview:
- CPU-side requester for CXU-L2: the issuing end of the L2 request/response interface.
- Accepts custom-instruction commands from a core pipeline, issues them as CXU-L2 requests to one or more L2 CXUs, and buffers their responses in an in-order FIFO.
- Returns responses to the core under valid/ready.
- Uses credits so that every issued request has guaranteed response storage; resp_ready therefore never deasserts because of a full FIFO.

Parameters:
- CXU_N_CXUS, 1, number of addressable CXUs; CXU_ID_W = max(1, clog2(CXU_N_CXUS)).
- CXU_FUNC_ID_W, 10, function-ID width.
- CXU_DATA_W, 32, operand/result width.
- CXU_STATUS_W, 3, response status width.
- DEPTH, 4, maximum commands in flight plus buffered (power of 2, >= 2).
- TIMEOUT, 255, response watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  clock enable; all state holds when low.
- cmd_valid  in  1  core command valid.
- cmd_ready  out  1  command accepted.
- cmd_cxu  in  CXU_ID_W  target CXU.
- cmd_func  in  CXU_FUNC_ID_W  function ID.
- cmd_data0  in  CXU_DATA_W  operand 0.
- cmd_data1  in  CXU_DATA_W  operand 1.
- req_valid  out  1  L2 request valid.
- req_ready  in  1  L2 request ready.
- req_cxu  out  CXU_ID_W  L2 request CXU ID.
- req_func  out  CXU_FUNC_ID_W  L2 request function ID.
- req_data0  out  CXU_DATA_W  L2 request operand 0.
- req_data1  out  CXU_DATA_W  L2 request operand 1.
- resp_valid  in  1  L2 response valid.
- resp_ready  out  1  L2 response ready.
- resp_status  in  CXU_STATUS_W  L2 response status.
- resp_data  in  CXU_DATA_W  L2 response data.
- rsp_valid  out  1  core response valid.
- rsp_ready  in  1  core response ready.
- rsp_status  out  CXU_STATUS_W  core response status.
- rsp_data  out  CXU_DATA_W  core response data.
- busy  out  1  credit count nonzero.
- err_unexp  out  1  sticky flag: response received with nothing in flight.

Behaviour:
- Reset (rst_n low, asynchronous): req_valid=0, rsp_valid=0, credit=0, inflight=0, FIFO empty, err_unexp=0. Request and response data registers have don't-care values.
- Handshakes below count only when clk_en=1.
- credit: 0..DEPTH.
  - +1 on a cmd handshake (cmd_valid && cmd_ready).
  - -1 on a core response handshake (rsp_valid && rsp_ready).
  - Both in the same cycle: unchanged.
- Request stage is a single output register.
  - cmd_ready = clk_en && credit<DEPTH && (!req_valid || req_ready).
  - On a cmd handshake, the req_* fields load from the cmd_* fields and req_valid=1 the next cycle.
  - Command to req_valid latency: 1 cycle.
  - While req_valid && !req_ready, all req_* outputs hold stable.
  - req_valid clears after a handshake unless a new command loads in the same cycle. This gives back-to-back issue at 1 request per cycle.
- inflight counts L2 requests handshaken and not yet responded.
  - +1 on a request handshake (req_valid && req_ready).
  - -1 on an accepted response.
- resp_ready = clk_en.
  - On resp_valid && resp_ready with inflight>0: push {resp_status, resp_data} into the FIFO.
  - With inflight==0: drop the response and set err_unexp. err_unexp clears only on reset.
- FIFO is DEPTH entries deep, in order. Wrap-around uses index-width pointers plus an occupancy count.
  - Overflow cannot occur: credit covers the request register, in-flight requests and FIFO entries.
- rsp_valid = FIFO non-empty; rsp_status/rsp_data = FIFO head.
- Push and pop on the same cycle are legal, including when the FIFO is full or empty. When the FIFO is empty, an L2 response appears at rsp_* the cycle after it is accepted (no bypass).
- busy = (credit != 0).
- Reset asserted mid-operation discards everything. Responses to pre-reset requests that arrive after reset set err_unexp.

Optional Feature:
- Macro: CXU_L2_INITIATOR_TIMEOUT_EN.
- When defined:
  - Adds a counter that increments each clk_en cycle while inflight>0.
  - Counter clears on any accepted response or when inflight==0.
  - When the counter reaches TIMEOUT, the block synthesizes a response {status=all-ones, data=0}, pushes it to the FIFO and decrements inflight. The flag output err_timeout (sticky, reset 0) is set.
  - A late real response for that command counts as unexpected only if inflight is 0 at that time.
- When not defined: no counter and no err_timeout port.

Test Plan:
- Single command cxu=0, func=5, data0=3, data1=4 with req_ready=1; the CXU responds 1 cycle later with status 0, data 7.
  - Expect: req_valid high cycle 1; rsp_valid high cycle 3 with data 7; busy drops after the rsp handshake.
- Backpressure: 6 commands, req_ready=1, rsp_ready=0.
  - Expect: exactly 4 accepted; cmd_ready=0 while credit=4.
  - After 1 rsp pop, cmd_ready returns next cycle.
  - All responses arrive in order (data 10, 11, 12, 13).
- req_ready=0 for 3 cycles with a pending request func=9.
  - Expect: req_* stable across those cycles; a single request handshake once req_ready=1.
- Simultaneous cmd handshake and rsp pop with credit=4 first reduced to 3.
  - Expect: credit remains 3 and the FIFO pointers wrap correctly over 10 iterations.
- resp_valid pulse with inflight=0.
  - Expect: response dropped, err_unexp=1 and held, FIFO stays empty.
- rst_n pulsed low asynchronously mid-flight with 2 outstanding.
  - Expect: outputs clear immediately; the subsequent stale response sets err_unexp.
  - With CXU_L2_INITIATOR_TIMEOUT_EN and TIMEOUT=8, an unanswered request yields status 7, data 0 after 8 cycles.
